// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: seeds and steps a 5-bit Galois LFSR, streaming a counted run over valid/ready.
module lfsr_run_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       seed,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [4:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             zero_seed
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [4:0] lfsr, lfsr_d, nxt;
  logic [LEN_W-1:0] rem, rem_d;
  logic zs_d;
  assign nxt = {lfsr[3], lfsr[2] ^ lfsr[4], lfsr[1], lfsr[0], lfsr[4]};
  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    rem_d   = rem;
    zs_d    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = (len != '0) ? RUN : DONE;
        lfsr_d  = (len == '0) ? lfsr : (seed == 5'b0) ? 5'b11111 : seed;
        zs_d    = (len != '0) && (seed == 5'b0);
        rem_d   = len;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        rem_d   = '0;
      end else if (out_ready) begin
        lfsr_d  = nxt;
        rem_d   = rem - LEN_W'(1);
        state_d = (rem == LEN_W'(1)) ? DONE : RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lfsr      <= 5'b11111;
      rem       <= '0;
      zero_seed <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      rem       <= rem_d;
      zero_seed <= zs_d;
    end
  end
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign out_data  = lfsr;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb_lfsr_run_ctrl: table-driven directed vectors plus abort, period and mid-run reset sequences.
module tb_lfsr_run_ctrl;
  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  logic [4:0] seed;
  logic [7:0] len;
  logic out_valid, busy, done, zero_seed;
  logic [4:0] out_data;
  int n_cmp = 0;
  int n_bad = 0;

  lfsr_run_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .len(len), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .done(done), .zero_seed(zero_seed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [4:0] seed;
    logic [7:0] len;
    logic       abort;
    logic       rdy;
    logic       v;
    logic [4:0] d;
    logic       b;
    logic       dn;
    logic       zs;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic st, input logic [4:0] sd, input logic [7:0] ln, input logic ab,
                     input logic rd, input logic v, input logic [4:0] d, input logic b,
                     input logic dn, input logic zs);
    vec_t e;
    e.start = st; e.seed = sd; e.len = ln; e.abort = ab; e.rdy = rd;
    e.v = v; e.d = d; e.b = b; e.dn = dn; e.zs = zs;
    tbl.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got v/d/b/dn/zs=%b_%b_%b_%b_%b, want %b_%b_%b_%b_%b", nm,
               got[8], got[7:3], got[2], got[1], got[0], exp[8], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] outs();
    return {out_valid, out_data, busy, done, zero_seed};
  endfunction

  function automatic logic [4:0] step(input logic [4:0] q);
    return {q[3], q[2] ^ q[4], q[1], q[0], q[4]};
  endfunction

  task automatic drive(input logic st, input logic [4:0] sd, input logic [7:0] ln,
                       input logic ab, input logic rd);
    start = st; seed = sd; len = ln; abort = ab; out_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp_d;
    logic [31:0] seen;
    int distinct;
    rst = 1'b0;
    drive(0, 5'h00, 8'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", outs(), {1'b0, 5'b11111, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    // basic run
    add(1, 5'b11111, 8'd4, 0, 1, 1, 5'b11111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b10111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b00111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b01110, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b11100, 0, 1, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b11100, 0, 0, 0);
    // backpressure after word 2
    add(1, 5'b11111, 8'd4, 0, 1, 1, 5'b11111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b10111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 0, 1, 5'b10111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 0, 1, 5'b10111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 0, 1, 5'b10111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b00111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b01110, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b11100, 0, 1, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b11100, 0, 0, 0);
    // zero seed
    add(1, 5'b00000, 8'd2, 0, 1, 1, 5'b11111, 1, 0, 1);
    add(0, 5'b00000, 8'd0, 0, 1, 1, 5'b10111, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b00111, 0, 1, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b00111, 0, 0, 0);
    // zero length, then start held through DONE is ignored
    add(1, 5'b01010, 8'd0, 0, 1, 0, 5'b00111, 0, 1, 0);
    add(1, 5'b01010, 8'd3, 0, 1, 0, 5'b00111, 0, 0, 0);
    // start during a len=3 run is ignored
    add(1, 5'b00001, 8'd3, 0, 1, 1, 5'b00001, 1, 0, 0);
    add(1, 5'b11111, 8'd5, 0, 1, 1, 5'b00010, 1, 0, 0);
    add(1, 5'b11111, 8'd5, 0, 1, 1, 5'b00100, 1, 0, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b01000, 0, 1, 0);
    add(0, 5'b00000, 8'd0, 0, 1, 0, 5'b01000, 0, 0, 0);
    // abort in IDLE has no effect
    add(0, 5'b00000, 8'd0, 1, 1, 0, 5'b01000, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].seed, tbl[i].len, tbl[i].abort, tbl[i].rdy);
      tick();
      cmp($sformatf("vec%0d", i), outs(), {tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].dn, tbl[i].zs});
    end

    // abort with simultaneous handshake on word 2
    drive(1, 5'b11111, 8'd4, 0, 1); tick();
    drive(0, 5'b00000, 8'd0, 0, 1); tick();
    cmp("abort_w2", outs(), {1'b1, 5'b10111, 1'b1, 1'b0, 1'b0});
    drive(0, 5'b00000, 8'd0, 1, 1); tick();
    cmp("abort_idle", outs(), {1'b0, 5'b10111, 1'b0, 1'b0, 1'b0});
    drive(0, 5'b00000, 8'd0, 0, 1); tick();
    cmp("abort_nodone", outs(), {1'b0, 5'b10111, 1'b0, 1'b0, 1'b0});

    // full period: 32 words from seed 1
    drive(1, 5'b00001, 8'd32, 0, 1); tick();
    drive(0, 5'b00000, 8'd0, 0, 1);
    exp_d = 5'b00001;
    seen = '0;
    distinct = 0;
    for (int w = 1; w <= 32; w++) begin
      cmp($sformatf("period_w%0d", w), outs(), {1'b1, exp_d, 1'b1, 1'b0, 1'b0});
      if (w <= 31 && out_data != 5'b0 && !seen[out_data]) begin
        seen[out_data] = 1'b1;
        distinct++;
      end
      if (w == 32) cmp("period_wrap", {4'b0, out_data}, {4'b0, 5'b00001});
      exp_d = step(exp_d);
      tick();
    end
    cmp("period_distinct", 9'(distinct), 9'd31);
    cmp("period_done", outs(), {1'b0, 5'b00010, 1'b0, 1'b1, 1'b0});
    tick();

    // asynchronous reset mid-run
    drive(1, 5'b10101, 8'd5, 0, 1); tick();
    drive(0, 5'b00000, 8'd0, 0, 1); tick();
    cmp("rst_pre", outs(), {1'b1, step(5'b10101), 1'b1, 1'b0, 1'b0});
    #2 rst = 1'b0;
    #1 cmp("rst_async", outs(), {1'b0, 5'b11111, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    drive(1, 5'b10101, 8'd1, 0, 1); tick();
    cmp("rst_restart", outs(), {1'b1, 5'b10101, 1'b1, 1'b0, 1'b0});
    drive(0, 5'b00000, 8'd0, 0, 1); tick();
    cmp("rst_done", outs(), {1'b0, 5'b00011, 1'b0, 1'b1, 1'b0});
    tick();
    cmp("rst_idle", outs(), {1'b0, 5'b00011, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
